// File: rtl/bist_pkg.sv
// March C- sequencer shared types: FSM states and the march element table.
// Each element lists its address direction, op count and the kind/data bit of each op.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_kind_t;

    typedef struct packed {
        logic     up;
        logic     two_ops;
        op_kind_t op0_kind;
        logic     op0_bit;
        op_kind_t op1_kind;
        logic     op1_bit;
    } elem_t;

    localparam int         MARCH_ELEMS = 6;
    localparam logic [2:0] LAST_ELEM   = 3'(MARCH_ELEMS - 1);

    // M0 up w0 | M1 up r0,w1 | M2 up r1,w0 | M3 down r0,w1 | M4 down r1,w0 | M5 up r0
    function automatic elem_t march_elem(input logic [2:0] e);
        elem_t t;
        case (e)
            3'd0:    t = '{1'b1, 1'b0, OP_WR, 1'b0, OP_WR, 1'b0};
            3'd1:    t = '{1'b1, 1'b1, OP_RD, 1'b0, OP_WR, 1'b1};
            3'd2:    t = '{1'b1, 1'b1, OP_RD, 1'b1, OP_WR, 1'b0};
            3'd3:    t = '{1'b0, 1'b1, OP_RD, 1'b0, OP_WR, 1'b1};
            3'd4:    t = '{1'b0, 1'b1, OP_RD, 1'b1, OP_WR, 1'b0};
            default: t = '{1'b1, 1'b0, OP_RD, 1'b0, OP_RD, 1'b0};
        endcase
        return t;
    endfunction

    function automatic logic elem_up(input logic [2:0] e);
        elem_t t;
        t = march_elem(e);
        return t.up;
    endfunction

endpackage

// File: rtl/march_addr_cnt.sv
// March address counter: loads 0 or N-1 at element start, steps up or down.
// Latency: addr updates on the clock after load/step; last is combinational from addr.
// No backpressure: the sequencer steps it at most once per cycle.
module march_addr_cnt #(
    parameter int ad_width = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_up,
    input  logic                load_down,
    input  logic                step,
    input  logic                dir,
    output logic [ad_width-1:0] addr,
    output logic                last
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr <= '0;
        end else if (load_up) begin
            addr <= '0;
        end else if (load_down) begin
            addr <= '1;
        end else if (step) begin
            addr <= dir ? addr + ad_width'(1) : addr - ad_width'(1);
        end
    end

    assign last = dir ? (addr == '1) : (addr == '0);

endmodule

// File: rtl/march_seq.sv
// March C- sequencer driving the RAM under test and the read-data comparator.
// Latency: first op in the cycle after the start edge; cmp_en/exp_data trail mem_re by RD_LAT.
// No backpressure: one op per cycle, start edges ignored while busy.
module march_seq
    import bist_pkg::*;
#(
    parameter int data_width = 4,
    parameter int ad_width   = 4,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ad_width-1:0]   mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [data_width-1:0] mem_wdata,
    output logic                  cmp_en,
    output logic [data_width-1:0] exp_data,
    output logic [2:0]            elem,
    output logic                  busy,
    output logic                  done
);

    state_t              state_q, state_d;
    logic                start_q;
    logic [2:0]          elem_q, elem_d;
    logic                op_q, op_d;
    logic [1:0]          drain_q, drain_d;
    logic                load_up, load_down, step;
    logic [ad_width-1:0] addr;
    logic                addr_last;
    elem_t               cur;
    op_kind_t            kind;
    logic                bitv;
    logic                last_op;
    logic                launch;
    logic                run;
    logic [RD_LAT-1:0]   re_pipe;
    logic [RD_LAT-1:0]   bit_pipe;

    assign cur     = march_elem(elem_q);
    assign kind    = op_q ? cur.op1_kind : cur.op0_kind;
    assign bitv    = op_q ? cur.op1_bit : cur.op0_bit;
    assign last_op = (op_q == cur.two_ops);
    assign launch  = start && !start_q && (state_q == IDLE || state_q == DONE);
    assign run     = (state_q == RUN);

    march_addr_cnt #(.ad_width(ad_width)) u_addr_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_up   (load_up),
        .load_down (load_down),
        .step      (step),
        .dir       (cur.up),
        .addr      (addr),
        .last      (addr_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            elem_q  <= '0;
            op_q    <= 1'b0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            elem_q  <= elem_d;
            op_q    <= op_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        elem_d    = elem_q;
        op_d      = op_q;
        drain_d   = drain_q;
        load_up   = 1'b0;
        load_down = 1'b0;
        step      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (launch) begin
                    state_d = RUN;
                    elem_d  = '0;
                    op_d    = 1'b0;
                    load_up = 1'b1;
                end
            end
            RUN: begin
                if (!last_op) begin
                    op_d = 1'b1;
                end else begin
                    op_d = 1'b0;
                    if (!addr_last) begin
                        step = 1'b1;
                    end else if (elem_q == LAST_ELEM) begin
                        state_d = (RD_LAT == 1) ? DONE : DRAIN;
                        drain_d = '0;
                    end else begin
                        // Next element starts at its own end of the address range.
                        elem_d    = elem_q + 3'd1;
                        load_up   = elem_up(elem_q + 3'd1);
                        load_down = !elem_up(elem_q + 3'd1);
                    end
                end
            end
            DRAIN: begin
                if (drain_q == 2'(RD_LAT - 2)) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_re    = run && (kind == OP_RD);
    assign mem_we    = run && (kind == OP_WR);
    assign mem_wdata = mem_we ? {data_width{bitv}} : '0;
    assign mem_addr  = run ? addr : '0;
    assign elem      = elem_q;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);

    // Expected bit is stored pre-gated by mem_re so exp_data is zero without a strobe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            re_pipe  <= '0;
            bit_pipe <= '0;
        end else begin
            re_pipe[0]  <= mem_re;
            bit_pipe[0] <= mem_re && bitv;
            for (int i = 1; i < RD_LAT; i++) begin
                re_pipe[i]  <= re_pipe[i-1];
                bit_pipe[i] <= bit_pipe[i-1];
            end
        end
    end

    assign cmp_en   = re_pipe[RD_LAT-1];
    assign exp_data = {data_width{bit_pipe[RD_LAT-1]}};

endmodule

// File: tb/tb_march_seq.sv
// Bench for march_seq: RD_LAT=1 and RD_LAT=3 instances against a cycle-indexed march op model
// and behavioural RAMs feeding a comparator.
module tb_march_seq;

    localparam int N    = 16;
    localparam int NOPS = 10 * N;

    logic clk, rst, start, fault;

    logic [3:0] a1_addr, a1_wd, a1_exp, a3_addr, a3_wd, a3_exp;
    logic       a1_we, a1_re, a1_cmp, a1_busy, a1_done;
    logic       a3_we, a3_re, a3_cmp, a3_busy, a3_done;
    logic [2:0] a1_elem, a3_elem;

    march_seq #(.data_width(4), .ad_width(4), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .mem_addr(a1_addr), .mem_we(a1_we),
        .mem_re(a1_re), .mem_wdata(a1_wd), .cmp_en(a1_cmp), .exp_data(a1_exp),
        .elem(a1_elem), .busy(a1_busy), .done(a1_done));

    march_seq #(.data_width(4), .ad_width(4), .RD_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start), .mem_addr(a3_addr), .mem_we(a3_we),
        .mem_re(a3_re), .mem_wdata(a3_wd), .cmp_en(a3_cmp), .exp_data(a3_exp),
        .elem(a3_elem), .busy(a3_busy), .done(a3_done));

    wire [19:0] av1 = {a1_we, a1_re, a1_addr, a1_wd, a1_cmp, a1_exp, a1_busy, a1_done, a1_elem};
    wire [19:0] av3 = {a3_we, a3_re, a3_addr, a3_wd, a3_cmp, a3_exp, a3_busy, a3_done, a3_elem};

    int checks = 0;
    int failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // March op list indexed by op cycle (1-based cycle c uses entry c-1).
    bit op_we[NOPS];
    bit op_bit[NOPS];
    int op_addr[NOPS];
    int op_elem[NOPS];

    task automatic build_ops();
        bit t_up[6]  = '{1, 1, 1, 0, 0, 1};
        int t_nop[6] = '{1, 2, 2, 2, 2, 1};
        bit t_w0[6]  = '{1, 0, 0, 0, 0, 0};
        bit t_b0[6]  = '{0, 0, 1, 0, 1, 0};
        bit t_b1[6]  = '{0, 1, 0, 1, 0, 0};
        int k = 0;
        for (int e = 0; e < 6; e++)
            for (int j = 0; j < N; j++)
                for (int o = 0; o < t_nop[e]; o++) begin
                    op_we[k]   = (o == 0) ? t_w0[e] : 1'b1;
                    op_bit[k]  = (o == 0) ? t_b0[e] : t_b1[e];
                    op_addr[k] = t_up[e] ? j : N - 1 - j;
                    op_elem[k] = e;
                    k++;
                end
    endtask

    function automatic void model_vec(input int lat, input bit act, input int c,
                                      output logic [19:0] v, output logic [19:0] m);
        v = '0;
        m = '1;
        if (act) begin
            if (c >= 1 && c <= NOPS) begin
                v[19]    = op_we[c-1];
                v[18]    = !op_we[c-1];
                v[17:14] = 4'(op_addr[c-1]);
                v[13:10] = op_we[c-1] ? {4{op_bit[c-1]}} : 4'h0;
                v[2:0]   = 3'(op_elem[c-1]);
            end else begin
                m[17:14] = '0;
                m[2:0]   = '0;
            end
            if (c - lat >= 1 && c - lat <= NOPS && !op_we[c-lat-1]) begin
                v[9]   = 1'b1;
                v[8:5] = {4{op_bit[c-lat-1]}};
            end
            v[4] = (c >= 1 && c <= NOPS + lat - 1);
            v[3] = (c >= NOPS + lat);
        end
    endfunction

    // Model state: cycles since each instance's launch edge.
    bit m_act[2];
    int m_cyc[2];
    bit m_prev_start = 1'b0;
    bit model_valid  = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_act[i] = 1'b0;
                m_cyc[i] = 0;
            end else if (start && !m_prev_start &&
                         !(m_act[i] && m_cyc[i] >= 1 && m_cyc[i] <= NOPS + (i == 0 ? 1 : 3) - 1)) begin
                m_act[i] = 1'b1;
                m_cyc[i] = 1;
            end else if (m_act[i] && m_cyc[i] < 100000) begin
                m_cyc[i] = m_cyc[i] + 1;
            end
        end
        m_prev_start = rst ? start : 1'b0;
        model_valid  = 1'b1;
    end

    // Behavioural RAMs: RD_LAT=1 with optional stuck-at-1 on bit 2 of addr 5, RD_LAT=3 clean.
    logic [3:0] ram1[N];
    logic [3:0] ram3[N];
    logic [3:0] rd1;
    logic [3:0] rd3_p[3];
    logic [6:0] tag1;

    function automatic logic [3:0] rd_ram1(input logic [3:0] a);
        logic [3:0] d;
        d = ram1[a];
        if (fault && a == 4'd5) d[2] = 1'b1;
        return d;
    endfunction

    always @(posedge clk) begin
        if (a1_we) ram1[a1_addr] <= a1_wd;
        rd1 <= a1_re ? rd_ram1(a1_addr) : 4'h0;
        if (a1_re) tag1 <= {a1_elem, a1_addr};
        if (a3_we) ram3[a3_addr] <= a3_wd;
        rd3_p[0] <= a3_re ? ram3[a3_addr] : 4'h0;
        rd3_p[1] <= rd3_p[0];
        rd3_p[2] <= rd3_p[1];
    end

    int         mm1, mm3;
    logic [2:0] fm_elem;
    logic [3:0] fm_addr;

    always @(negedge clk) begin
        logic [19:0] ev, mk;
        if (model_valid) begin
            model_vec(1, m_act[0], m_cyc[0], ev, mk);
            checks++;
            if (((av1 ^ ev) & mk) !== 20'h0) begin
                failures++;
                $display("FAIL cycle_l1 t=%0t cyc=%0d dut=%h model=%h mask=%h", $time, m_cyc[0], av1, ev, mk);
            end
            model_vec(3, m_act[1], m_cyc[1], ev, mk);
            checks++;
            if (((av3 ^ ev) & mk) !== 20'h0) begin
                failures++;
                $display("FAIL cycle_l3 t=%0t cyc=%0d dut=%h model=%h mask=%h", $time, m_cyc[1], av3, ev, mk);
            end
            checks++;
            if ((a1_we & a1_re) !== 1'b0 || (a3_we & a3_re) !== 1'b0) begin
                failures++;
                $display("FAIL we_re_excl t=%0t l1=%b%b l3=%b%b required no overlap", $time, a1_we, a1_re, a3_we, a3_re);
            end
            if (a1_cmp && rd1 !== a1_exp) begin
                if (mm1 == 0) {fm_elem, fm_addr} = tag1;
                mm1++;
            end
            if (a3_cmp && rd3_p[2] !== a3_exp) mm3++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One full run from a start pulse, optionally with an ignored start pulse mid-run.
    task automatic run_and_measure(input bit pulse_mid);
        int ops1 = 0, d1at = 0, d3at = 0, fre3 = 0, fc3 = 0, bad_m0 = 0;
        int pn;
        int eseq[$];
        pn  = $urandom_range(20, 150);
        mm1 = 0;
        mm3 = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_low_after_launch", {31'd0, a1_done}, 32'd0);
        chk("busy_high_after_launch", {31'd0, a3_busy}, 32'd1);
        for (int n = 1; n <= 400; n++) begin
            if (pulse_mid && n == pn) start = 1'b1;
            if (pulse_mid && n == pn + 1) start = 1'b0;
            if (a1_we || a1_re) begin
                ops1++;
                if (ops1 <= N && (!a1_we || a1_wd != 4'h0 || a1_addr != 4'(ops1 - 1))) bad_m0++;
                if (eseq.size() == 0 || eseq[$] != int'(a1_elem)) eseq.push_back(int'(a1_elem));
            end
            if (a3_re && fre3 == 0) fre3 = n;
            if (a3_cmp && fc3 == 0) fc3 = n;
            if (a1_done && d1at == 0) d1at = n;
            if (a3_done && d3at == 0) d3at = n;
            if (d1at != 0 && d3at != 0) break;
            @(negedge clk);
        end
        start = 1'b0;
        chk("op_cycles", ops1, NOPS);
        chk("m0_w0_ascending", bad_m0, 0);
        chk("done_cycle_l1", d1at, NOPS + 1);
        chk("done_cycle_l3", d3at, NOPS + 3);
        chk("cmp_lag_l3", fc3 - fre3, 3);
        chk("elem_count", eseq.size(), 6);
        for (int i = 0; i < eseq.size() && i < 6; i++) chk("elem_order", eseq[i], i);
    endtask

    initial begin
        int nz, rises;
        bit pb;
        rst   = 1'b0;
        start = 1'b0;
        fault = 1'b0;
        build_ops();
        for (int i = 0; i < N; i++) begin
            ram1[i] = 4'($urandom);
            ram3[i] = 4'($urandom);
        end
        repeat (3) @(negedge clk);

        // Reset mid-run, then stay idle without a start edge.
        rst = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat ($urandom_range(10, 120)) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs_l1", {12'd0, av1}, 32'd0);
        chk("reset_outputs_l3", {12'd0, av3}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        nz  = 0;
        repeat (20) begin
            @(negedge clk);
            if (av1 != 20'h0 || av3 != 20'h0) nz++;
        end
        chk("idle_after_reset", nz, 0);

        // Clean runs: the comparator must never see a mismatch.
        run_and_measure(1'b0);
        chk("mismatch_clean_l1", mm1, 0);
        chk("mismatch_clean_l3", mm3, 0);
        repeat ($urandom_range(1, 10)) @(negedge clk);
        run_and_measure(1'b1);
        chk("mismatch_pulsed_l1", mm1, 0);
        chk("done_held", {31'd0, a1_done}, 32'd1);

        // start held high: exactly one run.
        rises = 0;
        pb    = a1_busy;
        start = 1'b1;
        repeat (500) begin
            @(negedge clk);
            if (a1_busy && !pb) rises++;
            pb = a1_busy;
        end
        start = 1'b0;
        chk("held_start_runs", rises, 1);
        chk("held_start_done", {31'd0, a3_done}, 32'd1);
        repeat (2) @(negedge clk);

        // Stuck-at-1 on bit 2 of addr 5 in the RD_LAT=1 RAM.
        fault = 1'b1;
        run_and_measure(1'b0);
        chk("fault_detected", {31'd0, (mm1 != 0)}, 32'd1);
        chk("fault_elem", {29'd0, fm_elem}, 32'd1);
        chk("fault_addr", {28'd0, fm_addr}, 32'd5);
        chk("fault_free_l3", mm3, 0);
        fault = 1'b0;

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
